// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bundle for the register file.
// master = pipeline side, slave = register file.
interface regfile_scoreboard_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            wr_enable;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic            issue_stall;
   logic            flush;

   modport master (
      output wr_addr, wr_data, wr_enable,
      output rs1_addr, rs2_addr,
      output issue_valid, issue_rd, flush,
      input  rs1_data, rs2_data,
      input  rs1_busy, rs2_busy,
      input  issue_stall
   );

   modport slave (
      input  wr_addr, wr_data, wr_enable,
      input  rs1_addr, rs2_addr,
      input  issue_valid, issue_rd, flush,
      output rs1_data, rs2_data,
      output rs1_busy, rs2_busy,
      output issue_stall
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W integer register file with pending-write counters.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int CNT_W = 2
) (
   input logic                clk,
   input logic                reset,
   regfile_scoreboard_if.slave bus
);
   localparam int AW = $clog2(NREGS);
   localparam logic [CNT_W-1:0] CMAX = '1;

   logic [XLEN-1:0]  regs [NREGS];
   logic [CNT_W-1:0] cnt  [NREGS];
   logic [NREGS-1:0] inc;
   logic [NREGS-1:0] dec;
   logic             wr_ok;

   assign wr_ok = bus.wr_enable && (bus.wr_addr != '0);

   // stall when the destination's counter is already saturated
   always_comb begin
      bus.issue_stall = bus.issue_valid && (bus.issue_rd != '0) &&
                        (cnt[bus.issue_rd] == CMAX);
   end

   // per-register increment/decrement requests; x0 never participates
   always_comb begin
      inc = '0;
      dec = '0;
      for (int r = 1; r < NREGS; r++) begin
         inc[r] = bus.issue_valid && (bus.issue_rd == AW'(r)) &&
                  !bus.issue_stall;
         dec[r] = bus.wr_enable && (bus.wr_addr == AW'(r)) &&
                  (cnt[r] != '0);
      end
   end

   // data array: cleared on reset, x0 writes dropped, flush does not block
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (wr_ok) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // pending counters: reset/flush clear, inc and dec cancel out
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREGS; r++) begin
         if (reset || bus.flush) cnt[r] <= '0;
         else if (inc[r] && !dec[r]) cnt[r] <= cnt[r] + CNT_W'(1);
         else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
   end

   // read port 1, optionally forwarding the write in flight
   always_comb begin
      bus.rs1_data = '0;
      bus.rs1_busy = 1'b0;
      if (bus.rs1_addr != '0) begin
         bus.rs1_data = regs[bus.rs1_addr];
         bus.rs1_busy = (cnt[bus.rs1_addr] != '0);
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && (bus.wr_addr == bus.rs1_addr)) begin
            bus.rs1_data = bus.wr_data;
            if (cnt[bus.rs1_addr] == CNT_W'(1)) bus.rs1_busy = 1'b0;
         end
`endif
      end
   end

   // read port 2, same behavior as port 1
   always_comb begin
      bus.rs2_data = '0;
      bus.rs2_busy = 1'b0;
      if (bus.rs2_addr != '0) begin
         bus.rs2_data = regs[bus.rs2_addr];
         bus.rs2_busy = (cnt[bus.rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && (bus.wr_addr == bus.rs2_addr)) begin
            bus.rs2_data = bus.wr_data;
            if (cnt[bus.rs2_addr] == CNT_W'(1)) bus.rs2_busy = 1'b0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of data, x0, scoreboard and flush.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
   logic clk = 1'b0;
   logic reset;
   int vectors = 0;
   int miscompares = 0;

   regfile_scoreboard_if #(.XLEN(32), .AW(5)) bus ();

   regfile_scoreboard dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_enable   = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.flush       = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.wr_enable = 1'b1;
      bus.wr_addr   = a;
      bus.wr_data   = d;
   endtask

   task automatic iss(input logic [4:0] rd);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = rd;
   endtask

   task automatic test_reset();
      idle();
      bus.rs1_addr = '0;
      bus.rs2_addr = '0;
      reset = 1'b1;
      tick();
      tick();
      iss(5'd12);
      #1;
      vectors++;
      if (bus.issue_stall !== 1'b0) begin
         $display("FAIL reset_stall got %b want 0", bus.issue_stall);
         miscompares++;
      end
      reset = 1'b0;
      idle();
      for (int i = 0; i < 32; i++) begin
         bus.rs1_addr = 5'(i);
         bus.rs2_addr = 5'(31 - i);
         #1;
         vectors++;
         if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0 ||
             bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            $display("FAIL reset_read[%0d] got %h/%h busy %b%b want 0",
                     i, bus.rs1_data, bus.rs2_data,
                     bus.rs1_busy, bus.rs2_busy);
            miscompares++;
         end
      end
   endtask

   task automatic test_write();
      wr(5'd5, 32'hDEADBEEF);
      tick();
      idle();
      bus.rs1_addr = 5'd5;
      bus.rs2_addr = 5'd5;
      #1;
      vectors++;
      if (bus.rs1_data !== 32'hDEADBEEF || bus.rs2_data !== 32'hDEADBEEF) begin
         $display("FAIL write_x5 got %h/%h want deadbeef",
                  bus.rs1_data, bus.rs2_data);
         miscompares++;
      end
      vectors++;
      if (bus.rs1_busy !== 1'b0) begin
         $display("FAIL write_x5_busy got %b want 0", bus.rs1_busy);
         miscompares++;
      end
   endtask

   task automatic test_x0();
      wr(5'd0, 32'h1234);
      iss(5'd0);
      tick();
      idle();
      bus.rs1_addr = 5'd0;
      bus.rs2_addr = 5'd0;
      iss(5'd0);
      #1;
      vectors++;
      if (bus.rs1_data !== 32'h0 || bus.rs1_busy !== 1'b0 ||
          bus.rs2_busy !== 1'b0) begin
         $display("FAIL x0_read got %h busy %b want 0 busy 0",
                  bus.rs1_data, bus.rs1_busy);
         miscompares++;
      end
      vectors++;
      if (bus.issue_stall !== 1'b0) begin
         $display("FAIL x0_stall got %b want 0", bus.issue_stall);
         miscompares++;
      end
      idle();
   endtask

   task automatic test_saturate();
      bus.rs1_addr = 5'd7;
      for (int k = 0; k < 3; k++) begin
         iss(5'd7);
         #1;
         vectors++;
         if (bus.issue_stall !== 1'b0) begin
            $display("FAIL sat_early_stall[%0d] got %b want 0",
                     k, bus.issue_stall);
            miscompares++;
         end
         tick();
      end
      idle();
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b1) begin
         $display("FAIL sat_busy got %b want 1", bus.rs1_busy);
         miscompares++;
      end
      iss(5'd7);
      #1;
      vectors++;
      if (bus.issue_stall !== 1'b1) begin
         $display("FAIL sat_stall got %b want 1", bus.issue_stall);
         miscompares++;
      end
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b1) begin
         $display("FAIL sat_hold got %b want 1", bus.rs1_busy);
         miscompares++;
      end
      for (int k = 0; k < 3; k++) begin
         wr(5'd7, 32'h70 + 32'(k));
         tick();
         idle();
         #1;
         vectors++;
         if (bus.rs1_busy !== (k < 2)) begin
            $display("FAIL sat_drain[%0d] got %b want %b",
                     k, bus.rs1_busy, (k < 2));
            miscompares++;
         end
      end
      vectors++;
      if (bus.rs1_data !== 32'h72) begin
         $display("FAIL sat_data got %h want 72", bus.rs1_data);
         miscompares++;
      end
   endtask

   task automatic test_inc_dec();
      bus.rs1_addr = 5'd9;
      iss(5'd9);
      tick();
      idle();
      iss(5'd9);
      wr(5'd9, 32'h99);
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b1 || bus.rs1_data !== 32'h99) begin
         $display("FAIL incdec got %h busy %b want 99 busy 1",
                  bus.rs1_data, bus.rs1_busy);
         miscompares++;
      end
      wr(5'd9, 32'h98);
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b0) begin
         $display("FAIL incdec_drain got %b want 0", bus.rs1_busy);
         miscompares++;
      end
   endtask

   task automatic test_underflow();
      bus.rs1_addr = 5'd9;
      wr(5'd9, 32'h77);
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_data !== 32'h77 || bus.rs1_busy !== 1'b0) begin
         $display("FAIL underflow got %h busy %b want 77 busy 0",
                  bus.rs1_data, bus.rs1_busy);
         miscompares++;
      end
      iss(5'd9);
      tick();
      idle();
      wr(5'd9, 32'h78);
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b0) begin
         $display("FAIL underflow_cnt got %b want 0", bus.rs1_busy);
         miscompares++;
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_d;
      logic        exp_b;
      bus.rs1_addr = 5'd3;
      bus.rs2_addr = 5'd3;
      wr(5'd3, 32'h11111111);
      iss(5'd3);
      tick();
      idle();
      wr(5'd3, 32'hA5A5A5A5);
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_d = 32'hA5A5A5A5;
      exp_b = 1'b0;
`else
      exp_d = 32'h11111111;
      exp_b = 1'b1;
`endif
      vectors++;
      if (bus.rs1_data !== exp_d || bus.rs1_busy !== exp_b) begin
         $display("FAIL bypass_same got %h busy %b want %h busy %b",
                  bus.rs1_data, bus.rs1_busy, exp_d, exp_b);
         miscompares++;
      end
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_data !== 32'hA5A5A5A5 || bus.rs1_busy !== 1'b0) begin
         $display("FAIL bypass_next got %h busy %b want a5a5a5a5 busy 0",
                  bus.rs1_data, bus.rs1_busy);
         miscompares++;
      end
      iss(5'd3);
      tick();
      tick();
      idle();
      wr(5'd3, 32'h5A5A5A5A);
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_d = 32'h5A5A5A5A;
`else
      exp_d = 32'hA5A5A5A5;
`endif
      vectors++;
      if (bus.rs2_data !== exp_d || bus.rs2_busy !== 1'b1) begin
         $display("FAIL bypass_cnt2 got %h busy %b want %h busy 1",
                  bus.rs2_data, bus.rs2_busy, exp_d);
         miscompares++;
      end
      tick();
      idle();
      wr(5'd3, 32'h33);
      tick();
      idle();
   endtask

   task automatic test_flush();
      iss(5'd4);
      tick();
      iss(5'd6);
      tick();
      idle();
      bus.rs1_addr = 5'd4;
      bus.rs2_addr = 5'd6;
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
         $display("FAIL flush_pre got %b%b want 11",
                  bus.rs1_busy, bus.rs2_busy);
         miscompares++;
      end
      bus.flush = 1'b1;
      iss(5'd8);
      wr(5'd10, 32'hCAFE);
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
         $display("FAIL flush_clr got %b%b want 00",
                  bus.rs1_busy, bus.rs2_busy);
         miscompares++;
      end
      bus.rs1_addr = 5'd8;
      bus.rs2_addr = 5'd10;
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b0 || bus.rs2_data !== 32'hCAFE) begin
         $display("FAIL flush_x8 got busy %b data %h want 0 cafe",
                  bus.rs1_busy, bus.rs2_data);
         miscompares++;
      end
      bus.rs1_addr = 5'd4;
      wr(5'd4, 32'h4444);
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_data !== 32'h4444 || bus.rs1_busy !== 1'b0) begin
         $display("FAIL flush_wr got %h busy %b want 4444 busy 0",
                  bus.rs1_data, bus.rs1_busy);
         miscompares++;
      end
      iss(5'd4);
      tick();
      idle();
      wr(5'd4, 32'h4445);
      tick();
      idle();
      #1;
      vectors++;
      if (bus.rs1_busy !== 1'b0) begin
         $display("FAIL flush_cnt got %b want 0", bus.rs1_busy);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid();
      iss(5'd5);
      wr(5'd11, 32'hBEEF);
      tick();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.rs1_addr = 5'd5;
      bus.rs2_addr = 5'd11;
      #1;
      vectors++;
      if (bus.rs1_data !== 32'h0 || bus.rs1_busy !== 1'b0 ||
          bus.rs2_data !== 32'h0) begin
         $display("FAIL reset_mid got %h busy %b %h want 0",
                  bus.rs1_data, bus.rs1_busy, bus.rs2_data);
         miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_x0();
      test_saturate();
      test_inc_dec();
      test_underflow();
      test_bypass();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural integer register file with a per-register pending-write scoreboard. It is the receiving end of the writeback stage's register-file write interface (`wr_addr`/`wr_data`/`wr_enable`). It also serves decode with two read ports and RAW-hazard status for in-flight destination registers. Decode marks a destination pending at issue; the matching writeback retires it.

## Interface
Parameters:
- `XLEN`, 32, register data width.
- `NREGS`, 32, number of architectural registers (address width = clog2(NREGS) = 5).
- `CNT_W`, 2, width of each pending counter (max in-flight writes per register = 2^CNT_W − 1 = 3).

Ports:
- `clk` input 1: the single clock; every state element updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `wr_addr` input 5: write address, driven by writeback.
- `wr_data` input XLEN: write data, driven by writeback.
- `wr_enable` input 1: write strobe, driven by writeback.
- `rs1_addr` input 5: read port 1 address.
- `rs2_addr` input 5: read port 2 address.
- `rs1_data` output XLEN: read port 1 data, combinational.
- `rs2_data` output XLEN: read port 2 data, combinational.
- `rs1_busy` output 1: register `rs1_addr` has a pending write.
- `rs2_busy` output 1: register `rs2_addr` has a pending write.
- `issue_valid` input 1: decode issues an instruction that will write `issue_rd`.
- `issue_rd` input 5: destination of the issuing instruction.
- `issue_stall` output 1: the pending counter for `issue_rd` is saturated; decode must not issue.
- `flush` input 1: pipeline squash; clears all pending counters.

## Operation
- Storage: NREGS × XLEN array, plus one CNT_W-bit pending counter per register.
- x0:
  - Reads of address 0 always return 0 with busy=0.
  - Writes to address 0 are ignored.
  - Issue to rd=0 is ignored and never stalls.
- Write: on `wr_enable`=1 with `wr_addr`≠0, `reg[wr_addr]` ← `wr_data` at the clock edge.
- Counter update per register r, evaluated each cycle in this priority order:
  - reset → 0.
  - flush → 0. Any `issue_valid` and counter decrement in the same cycle are discarded. The data write still happens.
  - Otherwise:
    - inc = `issue_valid` & `issue_rd`==r & ~`issue_stall`
    - dec = `wr_enable` & `wr_addr`==r & count≠0
    - inc&dec → unchanged; inc → +1; dec → −1.
- Underflow guard: a write to a register whose count is 0 updates data only; the count stays 0.
- `issue_stall` = `issue_valid` & `issue_rd`≠0 & count[issue_rd]==max. While stalled, the counter does not increment.
- `rsN_busy` = (`rsN_addr`≠0) & count[`rsN_addr`]≠0, before bypass adjustment (see Configuration).
- `rsN_data` = `reg[rsN_addr]` (0 for x0), before bypass adjustment.

## Timing
- Reads are asynchronous. Zero-cycle latency from address to data and busy.
- A write lands at the rising edge. Without bypass it is visible on reads the following cycle.
- The issue → busy increment is visible on `rsN_busy` the cycle after `issue_valid`.
- `issue_stall` is combinational in the same cycle as `issue_valid`.
- Reset:
  - All registers = 0 and all counters = 0 after the reset edge.
  - Outputs are therefore `rs1_data`=`rs2_data`=0, busy=0, `issue_stall`=0.
  - Reset asserted mid-operation discards every pending count and written value.
- Simultaneous write and read of the same register: governed by `REGFILE_BYPASS_EN`.

## Configuration
- `REGFILE_BYPASS_EN` defined (write-through bypass):
  - Data: if `wr_enable` & `wr_addr`≠0 & `wr_addr`==`rsN_addr`, then `rsN_data` = `wr_data` in the same cycle.
  - Busy: `rsN_busy` is computed as if the decrement had already happened. It drops to 0 when count==1, and stays 1 when count>1.
- Undefined:
  - `rsN_data` returns the pre-write array value.
  - `rsN_busy` reflects the current count.
  - Decode sees the new value and cleared busy one cycle later.

## Test plan
- Reset, then read all 32 registers → every `rsN_data`=0, busy=0, `issue_stall`=0.
- Write x5=0xDEADBEEF, then read x5 next cycle → 0xDEADBEEF. Write x0=0x1234, then read x0 → 0, busy=0.
- Issue rd=7 three times → `rs1_busy`(x7)=1. Fourth issue → `issue_stall`=1 and count stays 3. Three writes to x7 → busy=0 after the third.
- Same-cycle issue rd=9 and write x9 with count=1 → count remains 1, busy=1. Write x9 with count=0 → data updated, count 0, no underflow.
- Bypass: read x3 while writing x3=0xA5A5A5A5 with count=1. With the macro → `rs1_data`=0xA5A5A5A5, busy=0 that cycle. Without it → old value, busy=1, then new value and busy=0 next cycle.
- Issue rd=4 and rd=6, then assert flush together with `issue_valid` rd=8 → all busy=0 next cycle, x8 not pending. A following write to x4 updates data and the count stays 0.
